// File: rtl/fft_input_packer_if.sv
// Sample stream into the FFT input packer and the packed 16-lane block bus out of it.
// master drives samples and consumes blocks; slave is the packer itself.
interface fft_input_packer_if #(
   parameter int WIDTH     = 9,
   parameter int NCHAN     = 16,
   parameter int FRAME_LEN = 512
);
   localparam int BW = $clog2(FRAME_LEN / NCHAN);

   logic                    s_valid;
   logic signed [WIDTH-1:0] s_i;
   logic signed [WIDTH-1:0] s_q;
   logic                    s_last;

   logic signed [WIDTH-1:0] in_i [0:NCHAN-1];
   logic signed [WIDTH-1:0] in_q [0:NCHAN-1];
   logic                    din_valid;
   logic                    frame_start;
   logic                    frame_err;
   logic [BW-1:0]           blk_cnt;

   modport master (
      output s_valid, s_i, s_q, s_last,
      input  in_i, in_q, din_valid, frame_start, frame_err, blk_cnt
   );

   modport slave (
      input  s_valid, s_i, s_q, s_last,
      output in_i, in_q, din_valid, frame_start, frame_err, blk_cnt
   );
endinterface

// File: rtl/fft_input_packer.sv
// Serial-to-parallel packer: collects NCHAN complex samples into a shadow bank,
// then presents them as one block to the FFT front-end while tracking frame alignment.
module fft_input_packer #(
   parameter int WIDTH     = 9,
   parameter int NCHAN     = 16,
   parameter int FRAME_LEN = 512
) (
   input logic               clk,
   input logic               rstn,
   fft_input_packer_if.slave bus
);
   localparam int LCW = $clog2(NCHAN);
   localparam int SCW = $clog2(FRAME_LEN);
   localparam logic [LCW-1:0] LC_LAST = LCW'(NCHAN - 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(FRAME_LEN - 1);

   logic [LCW-1:0]          lc;
   logic [SCW-1:0]          sc;
   logic [LCW-1:0]          lc_next;
   logic [SCW-1:0]          sc_next;
   logic signed [WIDTH-1:0] shadow_i [0:NCHAN-1];
   logic signed [WIDTH-1:0] shadow_q [0:NCHAN-1];
   logic                    lane_full;
   logic                    frame_end;
   logic                    early_last;
   logic                    missing_last;

   // An early s_last realigns both counters so the next sample opens a fresh frame at lane 0.
   always_comb begin
      lane_full    = (lc == LC_LAST);
      frame_end    = (sc == SC_LAST);
      early_last   = bus.s_last && !frame_end;
      missing_last = !bus.s_last && frame_end;
      lc_next      = lc + 1'b1;
      sc_next      = frame_end ? '0 : sc + 1'b1;
      if (early_last) begin
         lc_next = '0;
         sc_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         lc <= '0;
         sc <= '0;
      end else if (bus.s_valid) begin
         lc <= lc_next;
         sc <= sc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         for (int k = 0; k < NCHAN; k++) begin
            shadow_i[k] <= '0;
            shadow_q[k] <= '0;
         end
      end else if (bus.s_valid) begin
         shadow_i[lc] <= bus.s_i;
         shadow_q[lc] <= bus.s_q;
      end
   end

   // The last lane bypasses the shadow bank so the block is complete on the accepting edge.
   always_ff @(posedge clk) begin
      if (rstn) begin
         for (int k = 0; k < NCHAN; k++) begin
            bus.in_i[k] <= '0;
            bus.in_q[k] <= '0;
         end
         bus.din_valid   <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.blk_cnt     <= '0;
      end else begin
         bus.din_valid   <= bus.s_valid && lane_full;
         bus.frame_err   <= bus.s_valid && (early_last || missing_last);
         bus.frame_start <= bus.s_valid && lane_full && (sc[SCW-1:LCW] == '0);
         if (bus.s_valid && lane_full) begin
            for (int k = 0; k < NCHAN; k++) begin
               bus.in_i[k] <= (k == NCHAN - 1) ? bus.s_i : shadow_i[k];
               bus.in_q[k] <= (k == NCHAN - 1) ? bus.s_q : shadow_q[k];
            end
            bus.blk_cnt <= sc[SCW-1:LCW];
         end
      end
   end
endmodule

// File: tb/tb_fft_input_packer.sv
// Directed bench for fft_input_packer: block packing, gaps, framing errors, reset and extremes.
module tb_fft_input_packer;
   localparam int WIDTH     = 9;
   localparam int NCHAN     = 16;
   localparam int FRAME_LEN = 512;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fft_input_packer_if #(.WIDTH(WIDTH), .NCHAN(NCHAN), .FRAME_LEN(FRAME_LEN)) bus ();

   fft_input_packer #(.WIDTH(WIDTH), .NCHAN(NCHAN), .FRAME_LEN(FRAME_LEN)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   // Drives one cycle of input at a falling edge; outputs are then observed at the next falling edge.
   task automatic apply_stimulus(input logic v, input logic [8:0] i, input logic [8:0] q,
                                 input logic last);
      bus.s_valid = v;
      bus.s_i     = i;
      bus.s_q     = q;
      bus.s_last  = last;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b1;
      apply_stimulus(1'b1, 9'h1AA, 9'h055, 1'b1);
      rstn = 1'b0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      rstn = 1'b1;
      apply_stimulus(1'b1, 9'h123, 9'h045, 1'b1);
      apply_stimulus(1'b1, 9'h0F3, 9'h1C5, 1'b0);
      for (int j = 0; j < NCHAN; j++) begin
         checks++;
         if (bus.in_i[j] !== 9'h000 || bus.in_q[j] !== 9'h000) begin
            errors++;
            $display("[TB] FAIL reset_lane%0d: got i=%h q=%h expected 000", j, bus.in_i[j], bus.in_q[j]);
         end
      end
      checks++;
      if ({bus.din_valid, bus.frame_start, bus.frame_err} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 000", {bus.din_valid, bus.frame_start, bus.frame_err});
      end
      checks++;
      if (bus.blk_cnt !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reset_blk_cnt: got %0d expected 0", bus.blk_cnt);
      end
      rstn = 1'b0;
   endtask

   task automatic test_continuous();
      int pulses;
      int b;
      logic exp_dv;
      $display("[TB] test_continuous");
      do_reset();
      pulses = 0;
      for (int k = 0; k < FRAME_LEN; k++) begin
         apply_stimulus(1'b1, 9'(k), 9'(-k), k == FRAME_LEN - 1);
         exp_dv = (k % NCHAN == NCHAN - 1);
         if (bus.din_valid === 1'b1) pulses++;
         checks++;
         if (bus.din_valid !== exp_dv || bus.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cont_flags k=%0d: got dv=%b err=%b expected dv=%b err=0",
                     k, bus.din_valid, bus.frame_err, exp_dv);
         end
         if (exp_dv) begin
            b = k / NCHAN;
            for (int j = 0; j < NCHAN; j++) begin
               checks++;
               if (bus.in_i[j] !== 9'(NCHAN * b + j) || bus.in_q[j] !== 9'(-(NCHAN * b + j))) begin
                  errors++;
                  $display("[TB] FAIL cont_lane b=%0d j=%0d: got i=%h q=%h expected i=%h q=%h", b, j,
                           bus.in_i[j], bus.in_q[j], 9'(NCHAN * b + j), 9'(-(NCHAN * b + j)));
               end
            end
            checks++;
            if (bus.blk_cnt !== 5'(b) || bus.frame_start !== (b == 0)) begin
               errors++;
               $display("[TB] FAIL cont_block b=%0d: got blk_cnt=%0d fs=%b expected blk_cnt=%0d fs=%b",
                        b, bus.blk_cnt, bus.frame_start, b, (b == 0));
            end
         end else begin
            checks++;
            if (bus.frame_start !== 1'b0) begin
               errors++;
               $display("[TB] FAIL cont_fs_idle k=%0d: got %b expected 0", k, bus.frame_start);
            end
         end
      end
      checks++;
      if (pulses != FRAME_LEN / NCHAN) begin
         errors++;
         $display("[TB] FAIL cont_pulse_count: got %0d expected %0d", pulses, FRAME_LEN / NCHAN);
      end
   endtask

   task automatic test_gaps();
      int cycle;
      int last_pulse;
      int held_b;
      logic exp_dv;
      $display("[TB] test_gaps");
      do_reset();
      cycle = 0;
      last_pulse = -1;
      held_b = -1;
      for (int k = 0; k < FRAME_LEN; k++) begin
         apply_stimulus(1'b1, 9'(k), 9'(-k), k == FRAME_LEN - 1);
         cycle++;
         exp_dv = (k % NCHAN == NCHAN - 1);
         checks++;
         if (bus.din_valid !== exp_dv || bus.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_flags k=%0d: got dv=%b err=%b expected dv=%b err=0",
                     k, bus.din_valid, bus.frame_err, exp_dv);
         end
         if (bus.din_valid === 1'b1) begin
            if (last_pulse >= 0) begin
               checks++;
               if (cycle - last_pulse != 2 * NCHAN) begin
                  errors++;
                  $display("[TB] FAIL gap_spacing k=%0d: got %0d expected %0d", k, cycle - last_pulse, 2 * NCHAN);
               end
            end
            last_pulse = cycle;
         end
         if (exp_dv) begin
            held_b = k / NCHAN;
            for (int j = 0; j < NCHAN; j++) begin
               checks++;
               if (bus.in_i[j] !== 9'(NCHAN * held_b + j) || bus.in_q[j] !== 9'(-(NCHAN * held_b + j))) begin
                  errors++;
                  $display("[TB] FAIL gap_lane b=%0d j=%0d: got i=%h q=%h expected i=%h q=%h", held_b, j,
                           bus.in_i[j], bus.in_q[j], 9'(NCHAN * held_b + j), 9'(-(NCHAN * held_b + j)));
               end
            end
         end
         apply_stimulus(1'b0, 9'h0F0, 9'h10F, 1'b1);
         cycle++;
         checks++;
         if (bus.din_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_idle k=%0d: got dv=%b err=%b expected 0 0", k, bus.din_valid, bus.frame_err);
         end
         if (held_b >= 0) begin
            checks++;
            if (bus.in_i[0] !== 9'(NCHAN * held_b) || bus.in_q[NCHAN-1] !== 9'(-(NCHAN * held_b + NCHAN - 1))) begin
               errors++;
               $display("[TB] FAIL gap_hold k=%0d: got i0=%h q15=%h expected i0=%h q15=%h", k, bus.in_i[0],
                        bus.in_q[NCHAN-1], 9'(NCHAN * held_b), 9'(-(NCHAN * held_b + NCHAN - 1)));
            end
         end
      end
   endtask

   task automatic test_early_last();
      $display("[TB] test_early_last");
      do_reset();
      for (int k = 0; k <= 100; k++) begin
         apply_stimulus(1'b1, 9'(k), 9'(-k), k == 100);
         checks++;
         if (bus.din_valid !== (k % NCHAN == NCHAN - 1) || bus.frame_err !== (k == 100)) begin
            errors++;
            $display("[TB] FAIL early_flags k=%0d: got dv=%b err=%b expected dv=%b err=%b", k,
                     bus.din_valid, bus.frame_err, (k % NCHAN == NCHAN - 1), (k == 100));
         end
      end
      for (int j = 0; j < NCHAN; j++) begin
         apply_stimulus(1'b1, 9'(200 + j), 9'(-(200 + j)), 1'b0);
         checks++;
         if (bus.din_valid !== (j == NCHAN - 1) || bus.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_fresh_flags j=%0d: got dv=%b err=%b expected dv=%b err=0", j,
                     bus.din_valid, bus.frame_err, (j == NCHAN - 1));
         end
      end
      for (int j = 0; j < NCHAN; j++) begin
         checks++;
         if (bus.in_i[j] !== 9'(200 + j) || bus.in_q[j] !== 9'(-(200 + j))) begin
            errors++;
            $display("[TB] FAIL early_fresh_lane j=%0d: got i=%h q=%h expected i=%h q=%h", j,
                     bus.in_i[j], bus.in_q[j], 9'(200 + j), 9'(-(200 + j)));
         end
      end
      checks++;
      if (bus.frame_start !== 1'b1 || bus.blk_cnt !== 5'd0) begin
         errors++;
         $display("[TB] FAIL early_fresh_block: got fs=%b blk_cnt=%0d expected fs=1 blk_cnt=0",
                  bus.frame_start, bus.blk_cnt);
      end
   endtask

   task automatic test_missing_last();
      $display("[TB] test_missing_last");
      do_reset();
      for (int k = 0; k < FRAME_LEN; k++) begin
         apply_stimulus(1'b1, 9'(k), 9'(-k), 1'b0);
         checks++;
         if (bus.din_valid !== (k % NCHAN == NCHAN - 1) || bus.frame_err !== (k == FRAME_LEN - 1)) begin
            errors++;
            $display("[TB] FAIL missing_flags k=%0d: got dv=%b err=%b expected dv=%b err=%b", k,
                     bus.din_valid, bus.frame_err, (k % NCHAN == NCHAN - 1), (k == FRAME_LEN - 1));
         end
      end
      checks++;
      if (bus.blk_cnt !== 5'd31 || bus.frame_start !== 1'b0 || bus.in_i[NCHAN-1] !== 9'h1FF) begin
         errors++;
         $display("[TB] FAIL missing_last_block: got blk_cnt=%0d fs=%b i15=%h expected 31 0 1ff",
                  bus.blk_cnt, bus.frame_start, bus.in_i[NCHAN-1]);
      end
      for (int j = 0; j < NCHAN; j++) begin
         apply_stimulus(1'b1, 9'(j), 9'(-j), 1'b0);
         checks++;
         if (bus.din_valid !== (j == NCHAN - 1) || bus.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL missing_next_flags j=%0d: got dv=%b err=%b expected dv=%b err=0", j,
                     bus.din_valid, bus.frame_err, (j == NCHAN - 1));
         end
      end
      checks++;
      if (bus.frame_start !== 1'b1 || bus.blk_cnt !== 5'd0) begin
         errors++;
         $display("[TB] FAIL missing_next_block: got fs=%b blk_cnt=%0d expected fs=1 blk_cnt=0",
                  bus.frame_start, bus.blk_cnt);
      end
   endtask

   task automatic test_reset_mid();
      $display("[TB] test_reset_mid");
      do_reset();
      for (int k = 0; k < NCHAN + 7; k++) begin
         apply_stimulus(1'b1, 9'(8'h30 + k), 9'(9'h130 + k), 1'b0);
      end
      rstn = 1'b1;
      apply_stimulus(1'b1, 9'h0AA, 9'h0AA, 1'b0);
      rstn = 1'b0;
      for (int j = 0; j < NCHAN; j++) begin
         checks++;
         if (bus.in_i[j] !== 9'h000 || bus.in_q[j] !== 9'h000) begin
            errors++;
            $display("[TB] FAIL midreset_lane%0d: got i=%h q=%h expected 000", j, bus.in_i[j], bus.in_q[j]);
         end
      end
      checks++;
      if ({bus.din_valid, bus.frame_start, bus.frame_err} !== 3'b000 || bus.blk_cnt !== 5'd0) begin
         errors++;
         $display("[TB] FAIL midreset_flags: got flags=%b blk_cnt=%0d expected 000 0",
                  {bus.din_valid, bus.frame_start, bus.frame_err}, bus.blk_cnt);
      end
      for (int j = 0; j < NCHAN; j++) begin
         apply_stimulus(1'b1, 9'(8'h40 + j), 9'(9'h140 + j), 1'b0);
         checks++;
         if (bus.din_valid !== (j == NCHAN - 1)) begin
            errors++;
            $display("[TB] FAIL midreset_dv j=%0d: got %b expected %b", j, bus.din_valid, (j == NCHAN - 1));
         end
      end
      for (int j = 0; j < NCHAN; j++) begin
         checks++;
         if (bus.in_i[j] !== 9'(8'h40 + j) || bus.in_q[j] !== 9'(9'h140 + j)) begin
            errors++;
            $display("[TB] FAIL midreset_lane j=%0d: got i=%h q=%h expected i=%h q=%h", j,
                     bus.in_i[j], bus.in_q[j], 9'(8'h40 + j), 9'(9'h140 + j));
         end
      end
      checks++;
      if (bus.frame_start !== 1'b1 || bus.blk_cnt !== 5'd0) begin
         errors++;
         $display("[TB] FAIL midreset_block: got fs=%b blk_cnt=%0d expected fs=1 blk_cnt=0",
                  bus.frame_start, bus.blk_cnt);
      end
   endtask

   task automatic test_extremes();
      $display("[TB] test_extremes");
      do_reset();
      for (int j = 0; j < NCHAN; j++) begin
         apply_stimulus(1'b1, 9'h100, 9'h0FF, 1'b0);
      end
      checks++;
      if (bus.din_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL extreme_dv: got %b expected 1", bus.din_valid);
      end
      for (int j = 0; j < NCHAN; j++) begin
         checks++;
         if (bus.in_i[j] !== 9'h100 || bus.in_q[j] !== 9'h0FF) begin
            errors++;
            $display("[TB] FAIL extreme_lane j=%0d: got i=%h q=%h expected i=100 q=0ff", j,
                     bus.in_i[j], bus.in_q[j]);
         end
      end
   endtask

   initial begin
      rstn        = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_i     = '0;
      bus.s_q     = '0;
      bus.s_last  = 1'b0;
      @(negedge clk);
      test_reset();
      test_continuous();
      test_gaps();
      test_early_last();
      test_missing_last();
      test_reset_mid();
      test_extremes();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
